gmsk_burst_sequencer: RTL and testbench
=======================================

GMSK_BURST_SEQUENCER -- requirements
Module: gmsk_burst_sequencer

Interface
REQ-001 Parameter CLOCKS_PER_SAMPLE, default 8, clocks between sample_strobe pulses.
REQ-002 Parameter SAMPLES_PER_SYMBOL, default 128, sample_strobe pulses per symbol.
REQ-003 Parameter TAIL_SYMBOLS, default 3, zero tail bits at each burst end.
REQ-004 Parameter GUARD_SYMBOLS, default 8, strobed idle symbols after the trailing tail.
REQ-005 clock  in  1  system clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 burst_start  in  1  one-clock request to begin a burst.
REQ-008 burst_len  in  8  payload bit count, sampled with accepted burst_start.
REQ-009 bit_in / bit_valid  in  1/1  payload bit offer.
REQ-010 bit_ready  out  1  holding register empty; a bit transfers when bit_valid && bit_ready.
REQ-011 symbol_strobe / sample_strobe  out  1/1  one-clock pulses driving the modulator.
REQ-012 tx_bit  out  1  symbol value presented to the modulator.
REQ-013 tx_active  out  1  high during tail and payload symbols.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 underrun  out  1  sticky; set when payload bit is missing; cleared by accepted burst_start.

Function
REQ-016 FSM states SHALL be IDLE, TAIL_HEAD, PAYLOAD, TAIL_TAIL, GUARD.
REQ-017 burst_start SHALL be accepted only in IDLE; it is ignored while busy.
REQ-018 The clock after acceptance SHALL enter TAIL_HEAD with symbol_strobe and sample_strobe both high (latency 1).
REQ-019 While busy, sample_strobe SHALL pulse every CLOCKS_PER_SAMPLE clocks; symbol_strobe SHALL coincide with every SAMPLES_PER_SYMBOL-th sample_strobe, starting with the first.
REQ-020 Each state SHALL last an integer number of symbols: TAIL_HEAD and TAIL_TAIL TAIL_SYMBOLS, PAYLOAD burst_len, GUARD GUARD_SYMBOLS; transitions occur only on symbol_strobe clocks.
REQ-021 burst_len = 0 SHALL skip PAYLOAD (TAIL_HEAD -> TAIL_TAIL).
REQ-022 tx_bit SHALL update on the same edge that raises symbol_strobe and hold for the whole symbol; 0 in tails, GUARD and IDLE.
REQ-023 In PAYLOAD, each symbol_strobe SHALL consume the holding register into tx_bit; if empty, tx_bit = 0 and underrun sets, the burst continues unchanged.
REQ-024 bit_ready SHALL be high whenever the holding register is empty, in any state; a transfer and a consume on the same clock SHALL leave the register full with the new bit.
REQ-025 After the final GUARD symbol the FSM SHALL return to IDLE; strobes stop, and the next burst_start may be accepted the clock IDLE is re-entered.
REQ-026 Sample and symbol counters SHALL wrap to 0 exactly at CLOCKS_PER_SAMPLE-1 and SAMPLES_PER_SYMBOL-1; counter widths are $clog2 of the parameter.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, clear counters, holding register, tx_bit, strobes, tx_active, busy, underrun; bit_ready SHALL be 0 during reset and 1 the first clock after release.
REQ-028 Reset mid-burst SHALL abort the burst with no further strobes.

Configuration
REQ-029 Macro GMSK_DIFF_ENCODE_EN defined: tx_bit in PAYLOAD SHALL be d XOR previous d, previous d initialised to 1 at each TAIL_HEAD entry (GSM 05.04 style); tail bits remain raw 0.
REQ-030 Macro undefined: tx_bit SHALL be the raw payload bit, no encoding state.

Structure
REQ-031 A shared package gmsk_pkg SHALL hold the FSM state enum and the default CLOCKS_PER_SAMPLE / SAMPLES_PER_SYMBOL constants, also used by the modulator.
REQ-032 One sub-module gmsk_strobe_gen (sample/symbol counters, enable, strobe outputs) SHALL be instantiated; FSM and bit handling stay in the top.

Verification (bench params CLOCKS_PER_SAMPLE=2, SAMPLES_PER_SYMBOL=4, TAIL_SYMBOLS=3, GUARD_SYMBOLS=2)
REQ-033 burst_start, burst_len=4, bits 1,0,1,1 pre-offered -> symbol_strobe every 8 clocks from clock+1, tx_bit 0,0,0,1,0,1,1,0,0,0,0,0; busy for 96 clocks.
REQ-034 burst_len=0 -> 8 symbols (3 tail, 3 tail, 2 guard), tx_active high 48 clocks, no bits consumed.
REQ-035 burst_len=3, only bit 1 offered -> tx_bit 1,0,0 in payload, underrun high after second payload symbol_strobe, burst completes on schedule.
REQ-036 reset_n low in PAYLOAD -> same-clock busy=0, strobes 0; after release, burst_start starts fresh burst with underrun=0.
REQ-037 burst_start pulsed while busy -> ignored, timing unchanged; burst_start on IDLE re-entry clock -> accepted.
REQ-038 With GMSK_DIFF_ENCODE_EN, bits 1,1,0,0 -> payload tx_bit 0,0,1,0.

Source files
------------

// File: rtl/gmsk_pkg.sv
// Shared GMSK definitions: burst FSM states and default modulator timing,
// used by the burst sequencer and the modulator.
package gmsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAIL_HEAD,
        PAYLOAD,
        TAIL_TAIL,
        GUARD
    } gmsk_state_e;

    localparam int GMSK_CLOCKS_PER_SAMPLE  = 8;
    localparam int GMSK_SAMPLES_PER_SYMBOL = 128;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gmsk_burst_sequencer_if.sv
// Burst request, payload bit handshake and modulator drive signals of the
// GMSK burst sequencer.
interface gmsk_burst_sequencer_if;
    logic       burst_start;
    logic [7:0] burst_len;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       symbol_strobe;
    logic       sample_strobe;
    logic       tx_bit;
    logic       tx_active;
    logic       busy;
    logic       underrun;

    modport master (
        output burst_start, burst_len, bit_in, bit_valid,
        input  bit_ready, symbol_strobe, sample_strobe, tx_bit, tx_active, busy, underrun
    );

    modport slave (
        input  burst_start, burst_len, bit_in, bit_valid,
        output bit_ready, symbol_strobe, sample_strobe, tx_bit, tx_active, busy, underrun
    );
endinterface

// File: rtl/gmsk_strobe_gen.sv
// Sample/symbol strobe generator: registered one-clock pulses whose phase is
// restarted by start_i and which run only while en_i is high.
module gmsk_strobe_gen
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = GMSK_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = GMSK_SAMPLES_PER_SYMBOL
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start_i,          // restart phase: both strobes fire next clock
    input  logic en_i,             // sequencer is busy in the next clock
    output logic boundary_o,       // current clock is the last of a symbol
    output logic sample_strobe_o,
    output logic symbol_strobe_o
);

    localparam int SW = cnt_w(CLOCKS_PER_SAMPLE);
    localparam int YW = cnt_w(SAMPLES_PER_SYMBOL);
    localparam logic [SW-1:0] S_LAST = SW'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SAMPLES_PER_SYMBOL - 1);

    logic [SW-1:0] smp_cnt_q, smp_cnt_d;
    logic [YW-1:0] sym_cnt_q, sym_cnt_d;
    logic          smp_stb_q, smp_stb_d;
    logic          sym_stb_q, sym_stb_d;
    logic          smp_wrap;

    assign smp_wrap   = (smp_cnt_q == S_LAST);
    assign boundary_o = smp_wrap && (sym_cnt_q == Y_LAST);

    // Counters read 0 in the clock carrying their strobe.
    always_comb begin
        smp_cnt_d = '0;
        sym_cnt_d = '0;
        smp_stb_d = 1'b0;
        sym_stb_d = 1'b0;
        if (start_i) begin
            smp_stb_d = 1'b1;
            sym_stb_d = 1'b1;
        end else if (en_i) begin
            smp_cnt_d = smp_wrap ? '0 : smp_cnt_q + 1'b1;
            sym_cnt_d = sym_cnt_q;
            if (smp_wrap) begin
                sym_cnt_d = (sym_cnt_q == Y_LAST) ? '0 : sym_cnt_q + 1'b1;
                smp_stb_d = 1'b1;
                sym_stb_d = (sym_cnt_q == Y_LAST);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            smp_cnt_q <= '0;
            sym_cnt_q <= '0;
            smp_stb_q <= 1'b0;
            sym_stb_q <= 1'b0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            smp_stb_q <= smp_stb_d;
            sym_stb_q <= sym_stb_d;
        end
    end

    assign sample_strobe_o = smp_stb_q;
    assign symbol_strobe_o = sym_stb_q;

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst sequencer: head tail, payload, trailing tail and guard symbols
// with a one-bit payload holding register. GMSK_DIFF_ENCODE_EN enables
// differential encoding of payload bits.
module gmsk_burst_sequencer
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = GMSK_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = GMSK_SAMPLES_PER_SYMBOL,
    parameter int TAIL_SYMBOLS       = 3,
    parameter int GUARD_SYMBOLS      = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    gmsk_burst_sequencer_if.slave  bus
);

    gmsk_state_e state_q, state_d;
    logic [7:0]  sym_left_q, sym_left_d;   // symbols left in state after the current one
    logic [7:0]  len_q, len_d;
    logic        hold_full_q, hold_full_d;
    logic        hold_bit_q, hold_bit_d;
    logic        tx_bit_q, tx_bit_d;
    logic        underrun_q, underrun_d;
    logic        ready_en_q;
`ifdef GMSK_DIFF_ENCODE_EN
    logic        prev_q, prev_d;
`endif

    logic accept, boundary, sym_edge, consume, xfer;

    assign accept   = (state_q == IDLE) && bus.burst_start;
    assign sym_edge = (state_q != IDLE) && boundary;
    assign consume  = sym_edge && (state_d == PAYLOAD);
    assign xfer     = bus.bit_valid && bus.bit_ready;

    gmsk_strobe_gen #(
        .CLOCKS_PER_SAMPLE  (CLOCKS_PER_SAMPLE),
        .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL)
    ) u_strobe (
        .clock           (clock),
        .reset_n         (reset_n),
        .start_i         (accept),
        .en_i            (state_d != IDLE),
        .boundary_o      (boundary),
        .sample_strobe_o (bus.sample_strobe),
        .symbol_strobe_o (bus.symbol_strobe)
    );

    always_comb begin
        state_d    = state_q;
        sym_left_d = sym_left_q;
        len_d      = len_q;
        if (accept) begin
            state_d    = TAIL_HEAD;
            sym_left_d = 8'(TAIL_SYMBOLS - 1);
            len_d      = bus.burst_len;
        end else if (sym_edge) begin
            if (sym_left_q != 8'd0) begin
                sym_left_d = sym_left_q - 8'd1;
            end else begin
                case (state_q)
                    TAIL_HEAD: begin
                        if (len_q != 8'd0) begin
                            state_d    = PAYLOAD;
                            sym_left_d = len_q - 8'd1;
                        end else begin
                            state_d    = TAIL_TAIL;
                            sym_left_d = 8'(TAIL_SYMBOLS - 1);
                        end
                    end
                    PAYLOAD: begin
                        state_d    = TAIL_TAIL;
                        sym_left_d = 8'(TAIL_SYMBOLS - 1);
                    end
                    TAIL_TAIL: begin
                        if (GUARD_SYMBOLS == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = GUARD;
                            sym_left_d = 8'(GUARD_SYMBOLS - 1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // A consume empties the register; a transfer in the same clock refills it.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_bit_d  = hold_bit_q;
        tx_bit_d    = tx_bit_q;
        underrun_d  = underrun_q;
`ifdef GMSK_DIFF_ENCODE_EN
        prev_d      = prev_q;
        if (accept) prev_d = 1'b1;
`endif
        if (accept) underrun_d = 1'b0;
        if (accept || sym_edge) tx_bit_d = 1'b0;
        if (consume) begin
            hold_full_d = 1'b0;
            if (hold_full_q) begin
`ifdef GMSK_DIFF_ENCODE_EN
                tx_bit_d = hold_bit_q ^ prev_q;
                prev_d   = hold_bit_q;
`else
                tx_bit_d = hold_bit_q;
`endif
            end else begin
                underrun_d = 1'b1;
            end
        end
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_bit_d  = bus.bit_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sym_left_q  <= '0;
            len_q       <= '0;
            hold_full_q <= 1'b0;
            hold_bit_q  <= 1'b0;
            tx_bit_q    <= 1'b0;
            underrun_q  <= 1'b0;
            ready_en_q  <= 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
            prev_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            sym_left_q  <= sym_left_d;
            len_q       <= len_d;
            hold_full_q <= hold_full_d;
            hold_bit_q  <= hold_bit_d;
            tx_bit_q    <= tx_bit_d;
            underrun_q  <= underrun_d;
            ready_en_q  <= 1'b1;
`ifdef GMSK_DIFF_ENCODE_EN
            prev_q      <= prev_d;
`endif
        end
    end

    // ready_en_q keeps bit_ready low while reset is held.
    assign bus.bit_ready = ready_en_q && !hold_full_q;
    assign bus.tx_bit    = tx_bit_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tx_active = (state_q == TAIL_HEAD) || (state_q == PAYLOAD) ||
                           (state_q == TAIL_TAIL);
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Self-checking bench for gmsk_burst_sequencer: per-clock comparison of the
// strobe, state and bit outputs against a symbol-schedule reference model.
module tb_gmsk_burst_sequencer;

    localparam int CPS   = 2;
    localparam int SPS   = 4;
    localparam int TAIL  = 3;
    localparam int GUARD = 2;
    localparam int SPC   = CPS * SPS;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    gmsk_burst_sequencer_if bus ();

    gmsk_burst_sequencer #(
        .CLOCKS_PER_SAMPLE  (CPS),
        .SAMPLES_PER_SYMBOL (SPS),
        .TAIL_SYMBOLS       (TAIL),
        .GUARD_SYMBOLS      (GUARD)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Requests a burst (accepted at the next rising edge), offers the first
    // nbits of bits in order, optionally pulses burst_start during busy clock
    // 'pulse', and checks every clock up to and including the first idle one.
    // Returns mid-way through that idle clock so a following call chains.
    task automatic run_burst(input int len, input int nbits, input bit [15:0] bits, input int pulse);
        int         nsym;
        int         last;
        int         idx;
        int         s;
        int         ph;
        int         started;
        bit         act;
        bit         xfer;
        bit         prev;
        bit         exp_tx [0:31];
        logic [5:0] got;
        logic [5:0] want;
        nsym = 2 * TAIL + len + GUARD;
        last = nsym * SPC + 1;
        idx  = 0;
        prev = 1'b1;
        for (int i = 0; i < 32; i++) exp_tx[i] = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i < nbits) begin
`ifdef GMSK_DIFF_ENCODE_EN
                exp_tx[TAIL + i] = bits[i] ^ prev;
                prev = bits[i];
`else
                exp_tx[TAIL + i] = bits[i];
`endif
            end
        end
        bus.burst_len   = 8'(len);
        bus.burst_start = 1'b1;
        bus.bit_valid   = (nbits > 0);
        bus.bit_in      = bits[0];
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(negedge clock);
                act = (c <= nsym * SPC);
                s   = (c - 1) / SPC;
                ph  = (c - 1) % SPC;
                if (!act)            started = len;
                else if (s < TAIL)   started = 0;
                else if (s - TAIL + 1 > len) started = len;
                else                 started = s - TAIL + 1;
                want = {act, act && (ph == 0), act && (ph % CPS == 0),
                        act && (s < 2 * TAIL + len), act ? exp_tx[s] : 1'b0,
                        started > nbits};
                got  = {bus.busy, bus.symbol_strobe, bus.sample_strobe,
                        bus.tx_active, bus.tx_bit, bus.underrun};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL burst len=%0d clk=%0d {busy,sym,smp,txa,tx,ur} got=%b want=%b",
                             len, c, got, want);
                end
                if (c == last) break;
            end
            xfer = bus.bit_valid && bus.bit_ready;
            @(posedge clock); #1;
            if (xfer) idx++;
            bus.bit_valid   = (idx < nbits);
            bus.bit_in      = (idx < nbits) ? bits[idx] : 1'b0;
            bus.burst_start = (c + 1 == pulse);
            if (c + 1 == pulse) bus.burst_len = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        bus.burst_start = 1'b0;
        bus.burst_len   = 8'd0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
        reset_n         = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.busy, bus.symbol_strobe, bus.sample_strobe, bus.tx_active,
             bus.tx_bit, bus.underrun, bus.bit_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0000000", {bus.busy, bus.symbol_strobe,
                     bus.sample_strobe, bus.tx_active, bus.tx_bit, bus.underrun, bus.bit_ready});
        end
        reset_n = 1'b1;
        checks++;
        if (bus.bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_clock got=%b want=0", bus.bit_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.bit_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release ready=%b busy=%b want ready=1 busy=0",
                     bus.bit_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        run_burst(4, 4, 16'hD, 0);                       // bits 1,0,1,1
    endtask

    task automatic test_len0();
        run_burst(0, 1, 16'h1, 0);                       // offered bit must stay held
        checks++;
        if (bus.bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_bit_kept ready got=%b want=0", bus.bit_ready);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL len0_reset_clears_hold ready got=%b want=1", bus.bit_ready);
        end
    endtask

    task automatic test_underrun();
        run_burst(3, 1, 16'h1, 0);
        repeat (2) @(posedge clock); #1;
        run_burst(5, 2, 16'h2, 0);
        repeat (3) @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        bus.burst_len   = 8'd4;
        bus.burst_start = 1'b1;
        bus.bit_valid   = 1'b0;
        @(posedge clock); #1;
        bus.burst_start = 1'b0;
        repeat (TAIL * SPC) @(posedge clock);
        #1;                                              // first payload clock, no bit held
        checks++;
        if ({bus.symbol_strobe, bus.underrun, bus.busy} !== 3'b111) begin
            errors++;
            $display("FAIL mid_payload {sym,ur,busy} got=%b want=111",
                     {bus.symbol_strobe, bus.underrun, bus.busy});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.symbol_strobe, bus.sample_strobe, bus.tx_active,
             bus.tx_bit, bus.underrun, bus.bit_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_immediate got=%b want=0000000", {bus.busy, bus.symbol_strobe,
                     bus.sample_strobe, bus.tx_active, bus.tx_bit, bus.underrun, bus.bit_ready});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({bus.busy, bus.symbol_strobe, bus.sample_strobe} !== 3'b0) begin
                errors++;
                $display("FAIL reset_mid_held[%0d] {busy,sym,smp} got=%b want=000", i,
                         {bus.busy, bus.symbol_strobe, bus.sample_strobe});
            end
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_burst(2, 2, 16'h1, 0);                       // fresh burst, no underrun
    endtask

    task automatic test_ignore_start();
        run_burst(2, 2, 16'h2, 17);
        repeat (2) @(posedge clock); #1;
        run_burst(1, 1, 16'h1, (2 * TAIL + 1 + GUARD) * SPC);  // pulse on last busy clock
    endtask

    task automatic test_back_to_back();
        run_burst(2, 2, 16'h3, 0);
        run_burst(1, 1, 16'h0, 0);                       // accepted on idle re-entry clock
        run_burst(0, 0, 16'h0, 5);
    endtask

    task automatic test_random();
        int         len;
        int         nb;
        int         pulse;
        bit [15:0]  b;
        for (int it = 0; it < 8; it++) begin
            len   = $urandom_range(0, 7);
            nb    = (len == 0) ? 0 : $urandom_range(0, len);
            b     = 16'($urandom);
            pulse = ($urandom_range(0, 1) == 1) ?
                    $urandom_range(2, (2 * TAIL + len + GUARD) * SPC) : 0;
            run_burst(len, nb, b, pulse);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clock);
                #1;
            end
        end
    endtask

`ifdef GMSK_DIFF_ENCODE_EN
    task automatic test_diff();
        run_burst(4, 4, 16'h3, 0);                       // bits 1,1,0,0
        repeat (2) @(posedge clock); #1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        repeat (2) @(posedge clock); #1;
        test_len0();
        test_underrun();
        test_reset_mid();
        repeat (2) @(posedge clock); #1;
        test_ignore_start();
        repeat (2) @(posedge clock); #1;
        test_back_to_back();
        repeat (2) @(posedge clock); #1;
`ifdef GMSK_DIFF_ENCODE_EN
        test_diff();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
